// File: rtl/cu_pipe_regs_if.sv
// Control-word bundle between the stall mux / hazard unit and the pipeline
// control registers. The slave side is the register block itself.
interface cu_pipe_regs_if #(
  parameter int RD_W  = 5,
  parameter int CNT_W = 16
);
  logic             hold;
  logic             flush;

  logic [1:0]       SRD_in;
  logic [1:0]       PSW_LE_RE_in;
  logic             B_in;
  logic             UB_in;
  logic [2:0]       SOH_OP_in;
  logic [3:0]       ALU_OP_in;
  logic [3:0]       RAM_CTRL_in;
  logic             L_in;
  logic             RF_LE_in;
  logic [RD_W-1:0]  RD_in;

  logic [1:0]       EX_SRD;
  logic [1:0]       EX_PSW_LE_RE;
  logic             EX_B;
  logic             EX_UB;
  logic [2:0]       EX_SOH_OP;
  logic [3:0]       EX_ALU_OP;
  logic [3:0]       EX_RAM_CTRL;
  logic             EX_L;
  logic             EX_RF_LE;
  logic [RD_W-1:0]  EX_RD;

  logic [3:0]       MEM_RAM_CTRL;
  logic             MEM_L;
  logic             MEM_RF_LE;
  logic [RD_W-1:0]  MEM_RD;

  logic             WB_RF_LE;
  logic             WB_L;
  logic [RD_W-1:0]  WB_RD;

  logic             EX_valid;
  logic             MEM_valid;
  logic             WB_valid;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output hold, flush,
    output SRD_in, PSW_LE_RE_in, B_in, UB_in, SOH_OP_in, ALU_OP_in,
    output RAM_CTRL_in, L_in, RF_LE_in, RD_in,
    input  EX_SRD, EX_PSW_LE_RE, EX_B, EX_UB, EX_SOH_OP, EX_ALU_OP,
    input  EX_RAM_CTRL, EX_L, EX_RF_LE, EX_RD,
    input  MEM_RAM_CTRL, MEM_L, MEM_RF_LE, MEM_RD,
    input  WB_RF_LE, WB_L, WB_RD,
    input  EX_valid, MEM_valid, WB_valid, bubble_cnt
  );

  modport slave (
    input  hold, flush,
    input  SRD_in, PSW_LE_RE_in, B_in, UB_in, SOH_OP_in, ALU_OP_in,
    input  RAM_CTRL_in, L_in, RF_LE_in, RD_in,
    output EX_SRD, EX_PSW_LE_RE, EX_B, EX_UB, EX_SOH_OP, EX_ALU_OP,
    output EX_RAM_CTRL, EX_L, EX_RF_LE, EX_RD,
    output MEM_RAM_CTRL, MEM_L, MEM_RF_LE, MEM_RD,
    output WB_RF_LE, WB_L, WB_RD,
    output EX_valid, MEM_valid, WB_valid, bubble_cnt
  );
endinterface

// File: rtl/cu_pipe_regs.sv
// ID/EX, EX/MEM and MEM/WB control-word registers with per-stage valid,
// branch squash of ID/EX and a saturating count of bubbles entering ID/EX.
module cu_pipe_regs #(
  parameter int RD_W  = 5,
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           reset,
  cu_pipe_regs_if.slave bus
);

  typedef struct packed {
    logic [1:0]      srd;
    logic [1:0]      psw_le_re;
    logic            b;
    logic            ub;
    logic [2:0]      soh_op;
    logic [3:0]      alu_op;
    logic [3:0]      ram_ctrl;
    logic            l;
    logic            rf_le;
    logic [RD_W-1:0] rd;
    logic            valid;
  } idex_t;

  typedef struct packed {
    logic [3:0]      ram_ctrl;
    logic            l;
    logic            rf_le;
    logic [RD_W-1:0] rd;
    logic            valid;
  } exmem_t;

  typedef struct packed {
    logic            rf_le;
    logic            l;
    logic [RD_W-1:0] rd;
    logic            valid;
  } memwb_t;

  idex_t            idex_q, idex_d;
  exmem_t           exmem_q, exmem_d;
  memwb_t           memwb_q, memwb_d;
  logic [CNT_W-1:0] bubble_q;
  logic             word_active;
  logic             cnt_sat;

  // RD is not a control field: a word with only RD set is still a bubble.
  assign word_active = |{bus.SRD_in, bus.PSW_LE_RE_in, bus.B_in, bus.UB_in,
                         bus.SOH_OP_in, bus.ALU_OP_in, bus.RAM_CTRL_in,
                         bus.L_in, bus.RF_LE_in};

  assign cnt_sat = &bubble_q;

  // A bubble is forced to all-zero so RD never leaks to the hazard logic.
  always_comb begin
    idex_d = '0;
    if (!bus.flush && word_active) begin
      idex_d.srd       = bus.SRD_in;
      idex_d.psw_le_re = bus.PSW_LE_RE_in;
      idex_d.b         = bus.B_in;
      idex_d.ub        = bus.UB_in;
      idex_d.soh_op    = bus.SOH_OP_in;
      idex_d.alu_op    = bus.ALU_OP_in;
      idex_d.ram_ctrl  = bus.RAM_CTRL_in;
      idex_d.l         = bus.L_in;
      idex_d.rf_le     = bus.RF_LE_in;
      idex_d.rd        = bus.RD_in;
      idex_d.valid     = 1'b1;
    end
  end

  always_comb begin
    exmem_d          = '0;
    exmem_d.ram_ctrl = idex_q.ram_ctrl;
    exmem_d.l        = idex_q.l;
    exmem_d.rf_le    = idex_q.rf_le;
    exmem_d.rd       = idex_q.rd;
    exmem_d.valid    = idex_q.valid;
  end

  always_comb begin
    memwb_d       = '0;
    memwb_d.rf_le = exmem_q.rf_le;
    memwb_d.l     = exmem_q.l;
    memwb_d.rd    = exmem_q.rd;
    memwb_d.valid = exmem_q.valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else if (!bus.hold) begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_q <= '0;
    end else if (!bus.hold && !idex_d.valid && !cnt_sat) begin
      bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  assign bus.EX_SRD       = idex_q.srd;
  assign bus.EX_PSW_LE_RE = idex_q.psw_le_re;
  assign bus.EX_B         = idex_q.b;
  assign bus.EX_UB        = idex_q.ub;
  assign bus.EX_SOH_OP    = idex_q.soh_op;
  assign bus.EX_ALU_OP    = idex_q.alu_op;
  assign bus.EX_RAM_CTRL  = idex_q.ram_ctrl;
  assign bus.EX_L         = idex_q.l;
  assign bus.EX_RF_LE     = idex_q.rf_le;
  assign bus.EX_RD        = idex_q.rd;
  assign bus.EX_valid     = idex_q.valid;

  assign bus.MEM_RAM_CTRL = exmem_q.ram_ctrl;
  assign bus.MEM_L        = exmem_q.l;
  assign bus.MEM_RF_LE    = exmem_q.rf_le;
  assign bus.MEM_RD       = exmem_q.rd;
  assign bus.MEM_valid    = exmem_q.valid;

  assign bus.WB_RF_LE     = memwb_q.rf_le;
  assign bus.WB_L         = memwb_q.l;
  assign bus.WB_RD        = memwb_q.rd;
  assign bus.WB_valid     = memwb_q.valid;

  assign bus.bubble_cnt   = bubble_q;

endmodule
